dp_port_arbiter: RTL and testbench

- Shares the single data-pointer port of the bus control unit between N_REQ requesters: execution unit, interrupt vector/stack sequencer, and string unit.
- Each requester uses the same edge-triggered toggle handshake as the data-pointer port (req != ack means pending).
- The arbiter selects a winner, forwards that requester's transfer descriptor, waits for completion and returns read data.
- Supports locked multi-transfer sequences, e.g. far-pointer loads and interrupt frame pushes.

---
 rtl/dp_port_arbiter_pkg.sv | 25 ++
 rtl/dp_port_arbiter_priority_select.sv | 30 +++
 rtl/dp_port_arbiter.sv | 153 +++++++++++++++
 tb/tb_dp_port_arbiter.sv | 289 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dp_port_arbiter_pkg.sv
// rtl/dp_port_arbiter_pkg.sv - shared types for the data-pointer port arbiter
package dp_port_arbiter_pkg;

    typedef enum logic [1:0] {
        SREG_ES = 2'd0,
        SREG_CS = 2'd1,
        SREG_SS = 2'd2,
        SREG_DS = 2'd3
    } sreg_index_e;

    typedef struct packed {
        logic [15:0] addr;
        logic [15:0] dout;
        sreg_index_e sreg;
        logic        write;
        logic        wide;
        logic        io;
    } dp_desc_t;

    typedef enum logic {
        ARB_IDLE = 1'b0,
        ARB_WAIT = 1'b1
    } arb_state_e;

endpackage

// File: rtl/dp_port_arbiter_priority_select.sv
// rtl/dp_port_arbiter_priority_select.sv - lowest-index-first select, optionally restricted to one index
module dp_port_arbiter_priority_select #(
    parameter int N_REQ = 3,
    parameter int GW    = 2
) (
    input  logic [N_REQ-1:0] pending,
    input  logic             lock_en,
    input  logic [GW-1:0]    lock_idx,
    output logic             valid,
    output logic [GW-1:0]    idx
);

    logic [N_REQ-1:0] eligible;

    always_comb begin
        eligible = pending;
        if (lock_en) begin
            eligible = pending & (N_REQ'(1) << lock_idx);
        end
        valid = |eligible;
        idx   = '0;
        // Walk downward so the lowest eligible index is the last one written.
        for (int i = N_REQ - 1; i >= 0; i--) begin
            if (eligible[i]) begin
                idx = GW'(i);
            end
        end
    end

endmodule

// File: rtl/dp_port_arbiter.sv
// rtl/dp_port_arbiter.sv - shares the data-pointer port between toggle-handshake requesters
module dp_port_arbiter
    import dp_port_arbiter_pkg::*;
#(
    parameter int N_REQ = 3,
    localparam int GW   = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   ce_1,
    input  logic                   ce_2,
    input  logic [N_REQ-1:0]       rq_req,
    output logic [N_REQ-1:0]       rq_ack,
    input  logic [N_REQ-1:0]       rq_lock,
    input  logic [N_REQ-1:0][15:0] rq_addr,
    input  logic [N_REQ-1:0][15:0] rq_dout,
    input  sreg_index_e [N_REQ-1:0] rq_sreg,
    input  logic [N_REQ-1:0]       rq_write,
    input  logic [N_REQ-1:0]       rq_wide,
    input  logic [N_REQ-1:0]       rq_io,
    output logic [15:0]            rq_din,
    output logic [15:0]            dp_addr,
    output logic [15:0]            dp_dout,
    output sreg_index_e            dp_sreg,
    output logic                   dp_write,
    output logic                   dp_wide,
    output logic                   dp_io,
    output logic                   dp_req,
    input  logic                   dp_ready,
    input  logic [15:0]            dp_din,
    output logic [GW-1:0]          grant,
    output logic                   busy,
    output logic                   locked
);

    arb_state_e       state_q, state_d;
    logic [N_REQ-1:0] ack_q, ack_d;
    logic             dp_req_q, dp_req_d;
    logic [15:0]      din_q, din_d;
    dp_desc_t         desc_q, desc_d;
    logic [GW-1:0]    grant_q, grant_d;
    logic             busy_q, busy_d;
    logic             locked_q, locked_d;
    logic             armed_q, armed_d;

    logic [N_REQ-1:0] pending;
    logic             sel_valid;
    logic [GW-1:0]    sel_idx;
    dp_desc_t         rq_desc [N_REQ];

    // Everything advances on phase 2; phase 1 belongs to the bus control unit.
    logic ce_1_unused;
    assign ce_1_unused = ce_1;

    assign pending = rq_req ^ ack_q;

    always_comb begin
        for (int i = 0; i < N_REQ; i++) begin
            rq_desc[i] = '{addr:  rq_addr[i],
                           dout:  rq_dout[i],
                           sreg:  rq_sreg[i],
                           write: rq_write[i],
                           wide:  rq_wide[i],
                           io:    rq_io[i]};
        end
    end

    dp_port_arbiter_priority_select #(
        .N_REQ (N_REQ),
        .GW    (GW)
    ) u_select (
        .pending  (pending),
        .lock_en  (locked_q),
        .lock_idx (grant_q),
        .valid    (sel_valid),
        .idx      (sel_idx)
    );

    always_comb begin
        state_d  = state_q;
        ack_d    = ack_q;
        dp_req_d = dp_req_q;
        din_d    = din_q;
        desc_d   = desc_q;
        grant_d  = grant_q;
        busy_d   = busy_q;
        locked_d = locked_q;
        armed_d  = armed_q;
        case (state_q)
            ARB_IDLE: begin
                if (sel_valid) begin
                    desc_d   = rq_desc[sel_idx];
                    dp_req_d = ~dp_req_q;
                    grant_d  = sel_idx;
                    busy_d   = 1'b1;
                    armed_d  = 1'b0;
                    state_d  = ARB_WAIT;
                end
            end
            ARB_WAIT: begin
                // dp_ready still reflects the previous request on the first phase 2.
                if (!armed_q) begin
                    armed_d = 1'b1;
                end else if (dp_ready) begin
                    din_d          = dp_din;
                    ack_d[grant_q] = ~ack_q[grant_q];
                    locked_d       = rq_lock[grant_q];
                    busy_d         = 1'b0;
                    state_d        = ARB_IDLE;
                end
            end
            default: state_d = ARB_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= ARB_IDLE;
            ack_q    <= '0;
            dp_req_q <= 1'b0;
            din_q    <= '0;
            desc_q   <= '0;
            grant_q  <= '0;
            busy_q   <= 1'b0;
            locked_q <= 1'b0;
            armed_q  <= 1'b0;
        end else if (ce_2) begin
            state_q  <= state_d;
            ack_q    <= ack_d;
            dp_req_q <= dp_req_d;
            din_q    <= din_d;
            desc_q   <= desc_d;
            grant_q  <= grant_d;
            busy_q   <= busy_d;
            locked_q <= locked_d;
            armed_q  <= armed_d;
        end
    end

    assign rq_ack   = ack_q;
    assign rq_din   = din_q;
    assign dp_addr  = desc_q.addr;
    assign dp_dout  = desc_q.dout;
    assign dp_sreg  = desc_q.sreg;
    assign dp_write = desc_q.write;
    assign dp_wide  = desc_q.wide;
    assign dp_io    = desc_q.io;
    assign dp_req   = dp_req_q;
    assign grant    = grant_q;
    assign busy     = busy_q;
    assign locked   = locked_q;

endmodule

// File: tb/tb_dp_port_arbiter.sv
// tb/tb_dp_port_arbiter.sv - randomized and directed bench against a transaction-level model
module tb_dp_port_arbiter;
    import dp_port_arbiter_pkg::*;

    localparam int N = 3;

    logic                clk = 1'b0;
    logic                reset = 1'b1;
    logic                ce_1 = 1'b0;
    logic                ce_2 = 1'b0;
    logic [N-1:0]        rq_req = '0;
    logic [N-1:0]        rq_ack;
    logic [N-1:0]        rq_lock = '0;
    logic [N-1:0][15:0]  rq_addr = '0;
    logic [N-1:0][15:0]  rq_dout = '0;
    sreg_index_e [N-1:0] rq_sreg = '0;
    logic [N-1:0]        rq_write = '0;
    logic [N-1:0]        rq_wide = '0;
    logic [N-1:0]        rq_io = '0;
    logic [15:0]         rq_din;
    logic [15:0]         dp_addr;
    logic [15:0]         dp_dout;
    sreg_index_e         dp_sreg;
    logic                dp_write, dp_wide, dp_io, dp_req, dp_ready;
    logic [15:0]         dp_din = '0;
    logic [1:0]          grant;
    logic                busy, locked;

    dp_port_arbiter #(.N_REQ(N)) dut (
        .clk(clk), .reset(reset), .ce_1(ce_1), .ce_2(ce_2),
        .rq_req(rq_req), .rq_ack(rq_ack), .rq_lock(rq_lock),
        .rq_addr(rq_addr), .rq_dout(rq_dout), .rq_sreg(rq_sreg),
        .rq_write(rq_write), .rq_wide(rq_wide), .rq_io(rq_io),
        .rq_din(rq_din), .dp_addr(dp_addr), .dp_dout(dp_dout),
        .dp_sreg(dp_sreg), .dp_write(dp_write), .dp_wide(dp_wide),
        .dp_io(dp_io), .dp_req(dp_req), .dp_ready(dp_ready),
        .dp_din(dp_din), .grant(grant), .busy(busy), .locked(locked)
    );

    always #5 clk = ~clk;

    int n_pass = 0;
    int n_total = 0;
    bit ph = 1'b0;

    // bus control unit model
    bit          bcu_ack = 1'b0;
    bit          bcu_active = 1'b0;
    int          bcu_cnt = 0;
    int          bcu_lat_next = 1;
    logic [15:0] bcu_din_next = '0;
    bit          bcu_rand = 1'b0;
    bit          glitch_en = 1'b0;
    bit          force_rdy = 1'b0;
    int          bcu_issues = 0;
    int          log_grant[$];
    logic [15:0] log_addr[$];

    assign dp_ready = force_rdy | (bcu_ack == dp_req);

    // transaction-level arbiter model
    bit [N-1:0]  m_ack = '0;
    bit          m_dp_req = 1'b0;
    logic [15:0] m_din = '0, m_addr = '0, m_dout = '0;
    int          m_sreg = 0;
    bit          m_write = 1'b0, m_wide = 1'b0, m_io = 1'b0;
    int          m_grant = 0;
    bit          m_busy = 1'b0, m_locked = 1'b0, m_seen = 1'b0;
    int          m_order[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    endtask

    task automatic bcu_step();
        force_rdy = 1'b0;
        if (reset) begin
            bcu_ack = 1'b0;
            bcu_active = 1'b0;
        end else if (ce_1) begin
            if (bcu_active) begin
                if (bcu_cnt == 0) begin
                    bcu_ack = ~bcu_ack;
                    dp_din = bcu_din_next;
                    bcu_active = 1'b0;
                end else begin
                    bcu_cnt--;
                end
            end else if (dp_req != bcu_ack) begin
                if (bcu_rand) begin
                    bcu_lat_next = $urandom_range(0, 4);
                    bcu_din_next = 16'($urandom);
                end
                bcu_active = 1'b1;
                bcu_cnt = bcu_lat_next;
                bcu_issues++;
                log_grant.push_back(int'(grant));
                log_addr.push_back(dp_addr);
            end
        end else if (ce_2 && glitch_en && m_busy && !m_seen) begin
            force_rdy = 1'b1;   // stale ready on the first phase 2 must be ignored
        end
    endtask

    task automatic model_step();
        bit rdy;
        int w;
        rdy = force_rdy || (bcu_ack == m_dp_req);
        if (reset) begin
            m_ack = '0; m_dp_req = 0; m_din = '0; m_addr = '0; m_dout = '0; m_sreg = 0;
            m_write = 0; m_wide = 0; m_io = 0; m_grant = 0; m_busy = 0; m_locked = 0; m_seen = 0;
        end else if (ce_2) begin
            if (!m_busy) begin
                w = -1;
                if (m_locked) begin
                    if (rq_req[m_grant] != m_ack[m_grant]) w = m_grant;
                end else begin
                    for (int i = N - 1; i >= 0; i--) if (rq_req[i] != m_ack[i]) w = i;
                end
                if (w >= 0) begin
                    m_addr = rq_addr[w]; m_dout = rq_dout[w]; m_sreg = int'(rq_sreg[w]);
                    m_write = rq_write[w]; m_wide = rq_wide[w]; m_io = rq_io[w];
                    m_dp_req = !m_dp_req; m_grant = w; m_busy = 1; m_seen = 0;
                    m_order.push_back(w);
                end
            end else if (!m_seen) begin
                m_seen = 1;
            end else if (rdy) begin
                m_din = dp_din;
                m_ack[m_grant] = !m_ack[m_grant];
                m_locked = rq_lock[m_grant];
                m_busy = 0;
            end
        end
    endtask

    task automatic compare();
        chk("rq_ack", 32'(rq_ack), 32'(m_ack));
        chk("dp_req", 32'(dp_req), 32'(m_dp_req));
        chk("rq_din", 32'(rq_din), 32'(m_din));
        chk("dp_addr", 32'(dp_addr), 32'(m_addr));
        chk("dp_dout", 32'(dp_dout), 32'(m_dout));
        chk("dp_sreg", 32'(dp_sreg), 32'(m_sreg));
        chk("dp_flags", {29'd0, dp_write, dp_wide, dp_io}, {29'd0, m_write, m_wide, m_io});
        chk("grant", 32'(grant), 32'(m_grant));
        chk("busy", 32'(busy), 32'(m_busy));
        chk("locked", 32'(locked), 32'(m_locked));
    endtask

    task automatic tick();
        ce_2 = ph;
        ce_1 = !ph;
        ph = !ph;
        bcu_step();
        model_step();
        @(posedge clk);
        @(negedge clk);
        compare();
    endtask

    task automatic issue(input int i, input logic [15:0] a, input logic [15:0] d, input sreg_index_e s,
                         input bit wr, input bit wd, input bit io, input bit lk);
        rq_addr[i] = a; rq_dout[i] = d; rq_sreg[i] = s;
        rq_write[i] = wr; rq_wide[i] = wd; rq_io[i] = io; rq_lock[i] = lk;
        rq_req[i] = ~rq_req[i];
    endtask

    task automatic wait_idle(input string name, input int budget);
        bit done;
        done = 1'b0;
        for (int k = 0; k < budget && !done; k++) begin
            tick();
            if (rq_req == rq_ack && !busy) done = 1'b1;
        end
        chk(name, 32'(done), 32'd1);
    endtask

    initial begin
        logic [N-1:0] acks0;
        int issues0, ord0, busy_cycles;

        reset = 1'b1;
        repeat (4) tick();
        chk("reset_dp_req", 32'(dp_req), 32'd0);
        chk("reset_busy", 32'(busy), 32'd0);
        chk("reset_ack", 32'(rq_ack), 32'd0);
        reset = 1'b0;
        repeat (2) tick();

        // single requester read
        bcu_lat_next = 1; bcu_din_next = 16'hBEEF;
        acks0 = rq_ack; issues0 = bcu_issues;
        issue(1, 16'h0010, 16'h0000, SREG_DS, 0, 1, 0, 0);
        wait_idle("t1_timeout", 100);
        chk("t1_din", 32'(rq_din), 32'h0000BEEF);
        chk("t1_issues", 32'(bcu_issues - issues0), 32'd1);
        chk("t1_addr", 32'(log_addr[$]), 32'h00000010);
        chk("t1_ack_diff", 32'(rq_ack ^ acks0), 32'b010);

        // three-way contention
        ord0 = log_grant.size(); issues0 = bcu_issues;
        issue(0, 16'h0100, 16'h1111, SREG_ES, 1, 1, 0, 0);
        issue(1, 16'h0200, 16'h2222, SREG_CS, 0, 0, 1, 0);
        issue(2, 16'h0300, 16'h3333, SREG_SS, 1, 0, 0, 0);
        wait_idle("t2_timeout", 200);
        chk("t2_issues", 32'(bcu_issues - issues0), 32'd3);
        chk("t2_order0", 32'(log_grant[ord0]), 32'd0);
        chk("t2_order1", 32'(log_grant[ord0+1]), 32'd1);
        chk("t2_order2", 32'(log_grant[ord0+2]), 32'd2);
        chk("t2_model_order", 32'(m_order[$]), 32'd2);

        // locked two-push sequence with a higher-priority requester waiting
        ord0 = log_grant.size();
        issue(2, 16'hFFFE, 16'hAAAA, SREG_SS, 1, 1, 0, 1);
        repeat (3) tick();
        issue(0, 16'h0400, 16'h4444, SREG_DS, 0, 1, 0, 0);
        for (int k = 0; k < 100 && rq_ack[2] != rq_req[2]; k++) tick();
        repeat (6) tick();
        chk("t3_locked", 32'(locked), 32'd1);
        chk("t3_hold_grant", 32'(grant), 32'd2);
        chk("t3_req0_waiting", 32'(rq_req[0] ^ rq_ack[0]), 32'd1);
        issue(2, 16'hFFFC, 16'hBBBB, SREG_SS, 1, 1, 0, 0);
        wait_idle("t3_timeout", 200);
        chk("t3_order0", 32'(log_grant[ord0]), 32'd2);
        chk("t3_order1", 32'(log_grant[ord0+1]), 32'd2);
        chk("t3_order2", 32'(log_grant[ord0+2]), 32'd0);
        chk("t3_second_push", 32'(log_addr[ord0+1]), 32'h0000FFFC);
        chk("t3_released", 32'(locked), 32'd0);

        // wait states
        bcu_lat_next = 5; busy_cycles = 0;
        issue(1, 16'h0500, 16'h5555, SREG_DS, 0, 1, 0, 0);
        for (int k = 0; k < 100 && rq_ack[1] != rq_req[1]; k++) begin
            tick();
            if (busy) busy_cycles++;
        end
        chk("t4_busy_cycles", 32'(busy_cycles), 32'd14);
        tick();

        // reset while a write is in flight
        bcu_lat_next = 4;
        issue(0, 16'h0600, 16'h6666, SREG_ES, 1, 1, 0, 0);
        repeat (5) tick();
        chk("t5_inflight", 32'(busy), 32'd1);
        reset = 1'b1; rq_req = '0; rq_lock = '0;
        tick();
        chk("t5_dp_req", 32'(dp_req), 32'd0);
        chk("t5_ack", 32'(rq_ack), 32'd0);
        chk("t5_busy", 32'(busy), 32'd0);
        reset = 1'b0;
        repeat (2) tick();
        bcu_lat_next = 1; bcu_din_next = 16'h5A5A;
        issue(2, 16'h0700, 16'h0000, SREG_DS, 0, 1, 0, 0);
        wait_idle("t5_timeout", 100);
        chk("t5_din", 32'(rq_din), 32'h00005A5A);

        // odd-address wide write: two bus cycles, one arbiter transfer
        bcu_lat_next = 3; issues0 = bcu_issues; acks0 = rq_ack;
        issue(1, 16'h0003, 16'h1234, SREG_DS, 1, 1, 0, 0);
        wait_idle("t6_timeout", 100);
        chk("t6_issues", 32'(bcu_issues - issues0), 32'd1);
        chk("t6_ack_diff", 32'(rq_ack ^ acks0), 32'b010);
        chk("t6_dout", 32'(dp_dout), 32'h00001234);
        chk("t6_addr", 32'(log_addr[$]), 32'h00000003);

        // randomized traffic
        bcu_rand = 1'b1; glitch_en = 1'b1;
        for (int k = 0; k < 2000; k++) begin
            for (int i = 0; i < N; i++) begin
                if (rq_req[i] == rq_ack[i] && $urandom_range(0, 5) == 0)
                    issue(i, 16'($urandom), 16'($urandom), sreg_index_e'($urandom_range(0, 3)),
                          1'($urandom), 1'($urandom), 1'($urandom), $urandom_range(0, 3) == 0);
            end
            tick();
        end
        for (int k = 0; k < 400 && !(rq_req == rq_ack && !busy && !locked); k++) begin
            if (locked && !busy && rq_req[grant] == rq_ack[grant])
                issue(int'(grant), 16'h0800, 16'h0000, SREG_DS, 0, 0, 0, 0);
            tick();
        end
        chk("drain_done", 32'({rq_req == rq_ack, busy, locked}), 32'b100);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
